// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the decode-side
// instruction port (stall, branch redirect, presented instruction).
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 8
);
    // Instruction memory side
    logic                mem_req;
    logic [PC_WIDTH-1:0] mem_addr;
    logic [31:0]         mem_rdata;
    logic                mem_ack;

    // Decode side
    logic                stall;
    logic                branch_valid;
    logic [PC_WIDTH-1:0] branch_target;
    logic [31:0]         instr;
    logic                instr_valid;
    logic [PC_WIDTH-1:0] instr_pc;
    logic [PC_WIDTH-1:0] pc;

    // The fetch unit drives requests and the presented instruction
    modport master (
        output mem_req, mem_addr, instr, instr_valid, instr_pc, pc,
        input  mem_rdata, mem_ack, stall, branch_valid, branch_target
    );

    // Memory and decode drive responses, stall and redirects
    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, instr_pc, pc,
        output mem_rdata, mem_ack, stall, branch_valid, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding memory request
// at a time, registers the returned word for decode, honours stall and
// branch redirects, and discards a fetch made stale by a redirect.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ISSUE,  // about to place a request at pc
        WAIT,   // request outstanding, waiting for mem_ack
        VALID   // instruction presented to decode
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH-1:0] ipc_q, ipc_d;
    logic [31:0]         instr_q, instr_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                kill_q, kill_d;   // outstanding fetch belongs to a redirected path

    // State and datapath registers; every output comes straight from here
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values computed below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ipc_q   <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state and next-datapath decision for the fetch FSM
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        kill_d  = kill_q;

        case (state_q)
            ISSUE: begin
                if (bus.branch_valid) begin
                    // Take the redirect first; the request goes out next cycle
                    pc_d = bus.branch_target;
                end else begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                    state_d = ISSUE;
                    if (bus.branch_valid) begin
                        // Returning word is from the abandoned path: drop it
                        pc_d = bus.branch_target;
                    end else if (!kill_q) begin
                        instr_d = bus.mem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        state_d = VALID;
                    end
                end else if (bus.branch_valid) begin
                    // Request address must stay put; remember to discard its data
                    pc_d   = bus.branch_target;
                    kill_d = 1'b1;
                end
            end

            VALID: begin
                if (bus.branch_valid) begin
                    valid_d = 1'b0;
                    pc_d    = bus.branch_target;
                    state_d = ISSUE;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + 1'b1;   // wraps modulo 2^PC_WIDTH
                    state_d = ISSUE;
                end
            end

            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder, a stimulus process
// (directed scenarios then random stall/branch traffic) and a monitor that
// scores every presented instruction against a program-order model.
module tb_instr_fetch_unit;

    localparam int PW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

    instr_fetch_unit #(
        .PC_WIDTH (PW),
        .RESET_PC (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Responder controls, written only by the stimulus process
    int   fixed_lat = 1;    // -1 selects random latency
    logic stale_ack = 1'b0;

    // Expected address of the next instruction decode will see
    logic [PW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] word_at(input logic [PW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    // Memory responder: ack each request after a chosen number of wait cycles
    initial begin
        int lat;
        int waited;
        lat = 0;
        waited = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stale_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end else if (!rst_n) begin
                bus.mem_ack = 1'b0;
                waited = 0;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                waited = 0;
            end else if (bus.mem_req) begin
                if (waited == 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (waited >= lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = word_at(bus.mem_addr);
                end else begin
                    waited++;
                end
            end
        end
    end

    // Monitor / scoreboard: compare each clock edge's effect with the model
    initial begin
        logic          p_rst, p_req, p_ack, p_branch, p_stall, p_valid;
        logic [PW-1:0] p_addr, p_target, p_ipc, e;
        logic [31:0]   p_instr;
        exp_q = {8'h00};
        forever begin
            @(posedge clk);
            cyc++;
            p_rst    = rst_n;
            p_req    = bus.mem_req;
            p_ack    = bus.mem_ack;
            p_branch = bus.branch_valid;
            p_target = bus.branch_target;
            p_stall  = bus.stall;
            p_valid  = bus.instr_valid;
            p_addr   = bus.mem_addr;
            p_ipc    = bus.instr_pc;
            p_instr  = bus.instr;
            #1;
            if (!p_rst || !rst_n) begin
                exp_q = {8'h00};
                continue;
            end
            if (!p_req && bus.mem_req) begin
                if (exp_q.size() == 0) timeout_fail("req_without_expected_pc");
                else check("req_addr", 32'(bus.mem_addr), 32'(exp_q[0]));
            end
            if (p_req && bus.mem_req) check("addr_stable", 32'(bus.mem_addr), 32'(p_addr));
            if (p_req && p_ack)       check("req_drop_after_ack", 32'(bus.mem_req), 32'h0);
            if (p_valid)              check("no_req_while_valid", 32'(p_req), 32'h0);
            if (bus.instr_valid && !p_valid) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_instr");
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", 32'(bus.instr_pc), 32'(e));
                    check("instr", bus.instr, word_at(e));
                end
            end
            if (p_valid) begin
                if (p_branch || !p_stall) begin
                    check("valid_drop", 32'(bus.instr_valid), 32'h0);
                end else begin
                    check("hold_valid", 32'(bus.instr_valid), 32'h1);
                    check("hold_instr", bus.instr, p_instr);
                    check("hold_instr_pc", 32'(bus.instr_pc), 32'(p_ipc));
                end
            end
            // Program-order rule: a redirect names the next instruction,
            // otherwise consuming one instruction moves on to the next address
            if (p_branch)                 exp_q = {p_target};
            else if (p_valid && !p_stall) exp_q = {PW'(p_ipc + 1'b1)};
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_branch(input logic [PW-1:0] target);
        bus.branch_valid  = 1'b1;
        bus.branch_target = target;
        step();
        bus.branch_valid  = 1'b0;
    endtask

    // Wait for the next rising edge of mem_req
    task automatic wait_new_req(input string name, output bit ok);
        logic prev;
        prev = bus.mem_req;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.mem_req && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = bus.mem_req;
        end
        if (!ok) timeout_fail(name);
    endtask

    // Wait for a presented instruction, optionally at a given address
    task automatic wait_valid(input string name, input bit match_pc, input logic [PW-1:0] pc_want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.instr_valid && (!match_pc || bus.instr_pc == pc_want)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    // Stimulus: directed scenarios followed by random stall/branch traffic
    initial begin
        bit ok;
        int seen;
        int at_cyc[4];
        logic [PW-1:0] at_pc[4];

        bus.stall         = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        repeat (2) step();
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr_pc", 32'(bus.instr_pc), 32'h0);
        rst_n = 1'b1;

        // Free run, two-cycle memory: one instruction every 4 cycles
        fixed_lat = 1;
        seen = 0;
        for (int i = 0; i < 60 && seen < 4; i++) begin
            step();
            if (bus.instr_valid) begin
                at_cyc[seen] = cyc;
                at_pc[seen]  = bus.instr_pc;
                seen++;
            end
        end
        if (seen < 4) timeout_fail("free_run");
        else begin
            for (int k = 0; k < 4; k++) check("free_run_pc", 32'(at_pc[k]), 32'(k));
            for (int k = 1; k < 4; k++) check("free_run_period", 32'(at_cyc[k] - at_cyc[k-1]), 32'd4);
        end

        // Stall while instruction at pc 2 is presented
        pulse_branch(8'h02);
        wait_valid("stall_wait_pc2", 1'b1, 8'h02, ok);
        if (ok) begin
            bus.stall = 1'b1;
            repeat (5) begin
                step();
                check("stall_no_req", 32'(bus.mem_req), 32'h0);
                check("stall_instr_pc", 32'(bus.instr_pc), 32'h2);
                check("stall_valid", 32'(bus.instr_valid), 32'h1);
            end
            bus.stall = 1'b0;
            step();
            step();
            check("after_stall_req", 32'(bus.mem_req), 32'h1);
            check("after_stall_addr", 32'(bus.mem_addr), 32'h3);
        end

        // Branch during WAIT: address held, data discarded, refetch at 0x40
        fixed_lat = 2;
        pulse_branch(8'h05);
        wait_new_req("req_at_5", ok);
        if (ok) begin
            check("wait_addr_5", 32'(bus.mem_addr), 32'h5);
            pulse_branch(8'h40);
            for (int i = 0; i < 10 && bus.mem_req; i++) begin
                check("kill_addr_held", 32'(bus.mem_addr), 32'h5);
                step();
            end
            check("kill_no_valid", 32'(bus.instr_valid), 32'h0);
            wait_new_req("req_at_40", ok);
            if (ok) check("redirect_addr_40", 32'(bus.mem_addr), 32'h40);
        end

        // Branch in the same cycle as mem_ack
        wait_new_req("req_before_ack_branch", ok);
        for (int i = 0; i < 10 && !bus.mem_ack; i++) step();
        pulse_branch(8'h10);
        check("ack_branch_no_valid", 32'(bus.instr_valid), 32'h0);
        wait_new_req("req_at_10", ok);
        if (ok) check("ack_branch_addr", 32'(bus.mem_addr), 32'h10);

        // Branch in VALID while stalled: branch wins
        wait_valid("valid_for_branch", 1'b0, '0, ok);
        if (ok) begin
            bus.stall = 1'b1;
            step();
            check("stalled_valid", 32'(bus.instr_valid), 32'h1);
            pulse_branch(8'h20);
            check("branch_beats_stall", 32'(bus.instr_valid), 32'h0);
            bus.stall = 1'b0;
            wait_new_req("req_at_20", ok);
            if (ok) check("branch_stall_addr", 32'(bus.mem_addr), 32'h20);
        end

        // PC wrap from all-ones
        pulse_branch(8'hFF);
        wait_valid("valid_at_ff", 1'b1, 8'hFF, ok);
        if (ok) begin
            wait_new_req("req_after_ff", ok);
            if (ok) check("wrap_addr", 32'(bus.mem_addr), 32'h0);
        end

        // Asynchronous reset mid-WAIT with a stale ack during reset
        wait_new_req("req_before_reset", ok);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(bus.mem_req), 32'h0);
        check("async_rst_valid", 32'(bus.instr_valid), 32'h0);
        check("async_rst_pc", 32'(bus.pc), 32'h0);
        stale_ack = 1'b1;
        repeat (2) step();
        stale_ack = 1'b0;
        repeat (2) step();
        check("rst_ignores_ack", 32'(bus.instr_valid), 32'h0);
        rst_n = 1'b1;
        wait_new_req("req_after_reset", ok);
        if (ok) check("restart_addr", 32'(bus.mem_addr), 32'h0);

        // Random stall / branch / memory-latency traffic
        fixed_lat = -1;
        for (int i = 0; i < 1500; i++) begin
            bus.stall         = ($urandom_range(0, 2) == 0);
            bus.branch_valid  = ($urandom_range(0, 9) == 0);
            bus.branch_target = PW'($urandom_range(0, 255));
            step();
        end
        bus.stall        = 1'b0;
        bus.branch_valid = 1'b0;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound on run time
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
